// File: rtl/arb_pkg.sv
// Shared types and sizes for the round-robin mux arbiter.
package arb_pkg;

   localparam int unsigned SEL_W   = 2;
   localparam int unsigned MAX_REQ = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
   import arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   win_c,
   output logic               valid_c
);

   logic [MAX_REQ-1:0] req_ext;
   logic [SEL_W-1:0]   idx;

   assign req_ext = MAX_REQ'(req);

   // Scan NUM_REQ candidates starting at the pointer; the first hit wins.
   always_comb begin
      win_c   = '0;
      valid_c = 1'b0;
      idx     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = SEL_W'((32'(ptr) + i) % NUM_REQ);
         if (!valid_c && req_ext[idx]) begin
            win_c   = idx;
            valid_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 datapath mux with hold limit and handoff bubble.
// Optional LOCK input (freezes the hold counter) is built when ARB_LOCK_EN is defined.
module rr_mux_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic               CLK,
   input  logic               RST,
`ifdef ARB_LOCK_EN
   input  logic               LOCK,
`endif
   input  logic [NUM_REQ-1:0] REQ,
   input  logic [NUM_REQ-1:0] DONE,
   output logic [NUM_REQ-1:0] GNT,
   output logic [SEL_W-1:0]   MUX_SEL,
   output logic               BUSY,
   output logic               TIMEOUT
);

   arb_state_t         state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] gnt_d;
   logic [SEL_W-1:0]   sel_d;
   logic               busy_d;
   logic               timeout_d;

   logic [SEL_W-1:0]   win_c;
   logic               win_valid_c;
   logic               lock_c;
   logic [MAX_REQ-1:0] req_ext_c;
   logic [MAX_REQ-1:0] done_ext_c;
   logic               own_req_c;
   logic               own_done_c;
   logic               limit_c;
   logic               release_c;
   logic [SEL_W-1:0]   ptr_next_c;

`ifdef ARB_LOCK_EN
   assign lock_c = LOCK;
`else
   assign lock_c = 1'b0;
`endif

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req     (REQ),
      .ptr     (ptr_q),
      .win_c   (win_c),
      .valid_c (win_valid_c)
   );

   // The owner index is MUX_SEL, which is stable for the whole grant.
   assign req_ext_c  = MAX_REQ'(REQ);
   assign done_ext_c = MAX_REQ'(DONE);
   assign own_req_c  = req_ext_c[MUX_SEL];
   assign own_done_c = done_ext_c[MUX_SEL];
   assign limit_c    = !lock_c && (cnt_q == CNT_W'(MAX_HOLD - 1));
   assign release_c  = own_done_c || !own_req_c || limit_c;
   assign ptr_next_c = (MUX_SEL == SEL_W'(NUM_REQ - 1)) ? '0 : SEL_W'(MUX_SEL + SEL_W'(1));

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = GNT;
      sel_d     = MUX_SEL;
      busy_d    = BUSY;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_valid_c) begin
               gnt_d   = NUM_REQ'(1) << win_c;
               sel_d   = win_c;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = OWN;
            end
         end
         OWN: begin
            if (release_c) begin
               gnt_d     = '0;
               busy_d    = 1'b0;
               ptr_d     = ptr_next_c;
               cnt_d     = '0;
               timeout_d = limit_c && own_req_c && !own_done_c;
               state_d   = GAP;
            end else if (!lock_c) begin
               cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         GNT     <= '0;
         MUX_SEL <= '0;
         BUSY    <= 1'b0;
         TIMEOUT <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         GNT     <= gnt_d;
         MUX_SEL <= sel_d;
         BUSY    <= busy_d;
         TIMEOUT <= timeout_d;
      end
   end

endmodule
